// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between N byte sources.
// Grants one byte per frame, tracks sender busy, and aborts grants whose busy never rises.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int BUSY_WAIT = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [N-1:0]     i_req_valid,
  input  logic [8*N-1:0]   i_req_data,
  output logic [N-1:0]     o_req_ack,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_busy,
  output logic [IDW-1:0]   o_grant_id,
  output logic             o_active,
  output logic             o_timeout
);

  localparam int WDW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [WDW-1:0]   r_wdog;

  logic             w_any;
  int               w_best;
  int               w_best_off;
  logic [7:0]       w_byte;
  logic [N-1:0]     w_onehot;
  logic             w_grant;
  logic             w_expire;

  // Winner is the set bit with the smallest distance upward from the pointer.
  always_comb begin
    w_any      = 1'b0;
    w_best     = 0;
    w_best_off = N;
    for (int i = 0; i < N; i++) begin
      if (i_req_valid[i] && (((i + N - int'(r_ptr)) % N) < w_best_off)) begin
        w_any      = 1'b1;
        w_best     = i;
        w_best_off = (i + N - int'(r_ptr)) % N;
      end
    end
  end

  always_comb begin
    w_byte   = '0;
    w_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (w_best == i) begin
        w_byte      = i_req_data[8*i +: 8];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && w_any && !i_tx_busy;
  // Busy rising on the last watchdog cycle takes priority over expiry.
  assign w_expire = (r_state == S_WAIT_BUSY) && !i_tx_busy &&
                    (r_wdog == WDW'(BUSY_WAIT - 1));

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr  <= IDW'((w_best + 1) % N);
        r_wdog <= '0;
      end else if (r_state == S_WAIT_BUSY) begin
        r_wdog <= r_wdog + WDW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy)     w_state_nxt = S_WAIT_DONE;
        else if (w_expire) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_active = (r_state != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      o_req_ack  <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_grant_id <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= w_grant;
      o_req_ack  <= w_grant ? w_onehot : '0;
      o_timeout  <= w_expire;
      if (w_grant) begin
        o_tx_data  <= w_byte;
        o_grant_id <= IDW'(w_best);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants are queued by the stimulus
// and checked by an independent monitor whenever the arbiter issues a start.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic [3:0]   i_req_valid;
  logic [31:0]  i_req_data;
  logic [3:0]   o_req_ack;
  logic         o_tx_start;
  logic [7:0]   o_tx_data;
  logic         i_tx_busy;
  logic [1:0]   o_grant_id;
  logic         o_active;
  logic         o_timeout;

  uart_tx_arbiter #(.N(N), .IDW(2), .BUSY_WAIT(16)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ack   (o_req_ack),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy),
    .o_grant_id  (o_grant_id),
    .o_active    (o_active),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  logic [3:0] m_oh;
  logic [3:0] prev_ack = 4'b0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  // Monitor: every start/ack must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (!i_rstn && prev_ack != 4'b0) chk("ack_one_cycle", o_req_ack, 0);
    if (o_tx_start || o_req_ack != 4'b0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got id %0d data 0x%0h, expected no grant",
                 o_grant_id, o_tx_data);
      end else begin
        m_e  = sb.pop_front();
        m_oh = 4'b0001 << m_e.id;
        chk("mon_start", o_tx_start, 1);
        chk("mon_grant_id", o_grant_id, m_e.id);
        chk("mon_tx_data", o_tx_data, m_e.d);
        chk("mon_req_ack", o_req_ack, m_oh);
      end
    end
    prev_ack = o_req_ack;
  end

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge i_clk);
      if (o_tx_start) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: got no tx_start within 60 cycles, expected one", name);
    end
  endtask

  // Behavioral sender: busy for 5 cycles per frame; requests dropped on the last start.
  task automatic frames(input int n, input logic [3:0] v);
    i_req_valid = v;
    for (int k = 0; k < n; k++) begin
      wait_start("frame_start");
      if (k == n - 1) i_req_valid = 4'b0;
      i_tx_busy = 1'b1;
      repeat (5) @(negedge i_clk);
      i_tx_busy = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t_to;
    int n_to;
    bit bad;
    i_rstn      = 1'b1;
    i_req_valid = 4'b0;
    i_req_data  = 32'h0;
    i_tx_busy   = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_grant_id", o_grant_id, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_active", o_active, 0);
    i_rstn = 1'b0;
    @(negedge i_clk);

    // Single request
    i_req_data  = 32'h00A5_0000;
    push(2'd2, 8'hA5);
    i_req_valid = 4'b0100;
    @(negedge i_clk);
    chk("single_start", o_tx_start, 1);
    chk("single_ack", o_req_ack, 4'b0100);
    chk("single_data", o_tx_data, 8'hA5);
    chk("single_grant_id", o_grant_id, 2);
    i_req_valid = 4'b0;
    i_tx_busy   = 1'b1;
    repeat (10) @(negedge i_clk);
    i_tx_busy = 1'b0;
    chk("single_data_hold", o_tx_data, 8'hA5);
    chk("single_active_busy", o_active, 1);
    @(negedge i_clk);
    chk("single_active_fall", o_active, 0);

    // Round-robin from a freshly reset pointer
    i_rstn = 1'b1;
    @(negedge i_clk);
    i_rstn = 1'b0;
    i_req_data = 32'h4332_2110;
    push(2'd0, 8'h10);
    push(2'd1, 8'h21);
    push(2'd2, 8'h32);
    push(2'd3, 8'h43);
    push(2'd0, 8'h10);
    push(2'd1, 8'h21);
    frames(6, 4'b1111);
    repeat (3) @(negedge i_clk);

    // Wrap and skip: grant 2 sets pointer to 3
    i_req_data = 32'h0077_C35A;
    push(2'd2, 8'h77);
    frames(1, 4'b0100);
    push(2'd0, 8'h5A);
    push(2'd1, 8'hC3);
    push(2'd0, 8'h5A);
    frames(3, 4'b0011);
    repeat (3) @(negedge i_clk);

    // Watchdog expiry with busy stuck low
    push(2'd0, 8'h5A);
    i_req_valid = 4'b0001;
    wait_start("wd_start");
    i_req_valid = 4'b0;
    t_to = 0;
    n_to = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_timeout) begin
        n_to++;
        if (t_to == 0) t_to = c;
      end
      if (c == 16) chk("wd_idle_after", o_active, 0);
    end
    chk("wd_timeout_cycle", t_to, 16);
    chk("wd_timeout_pulses", n_to, 1);

    // Busy rises on the last watchdog cycle: no timeout
    push(2'd1, 8'hC3);
    i_req_valid = 4'b0010;
    wait_start("wd2_start");
    i_req_valid = 4'b0;
    n_to = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge i_clk);
      if (o_timeout) n_to++;
      if (c == 15) i_tx_busy = 1'b1;
    end
    chk("wd2_no_timeout", n_to, 0);
    chk("wd2_wait_done", o_active, 1);
    i_tx_busy = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("wd2_idle", o_active, 0);

    // Sender busy while idle blocks the grant
    i_tx_busy = 1'b1;
    push(2'd0, 8'h5A);
    i_req_valid = 4'b0001;
    bad = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_tx_start || o_req_ack != 4'b0) bad = 1'b1;
    end
    chk("busy_idle_blocked", bad, 0);
    i_tx_busy = 1'b0;
    @(negedge i_clk);
    chk("busy_idle_grant", o_tx_start, 1);
    i_req_valid = 4'b0;
    i_tx_busy   = 1'b1;
    repeat (3) @(negedge i_clk);
    i_tx_busy = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset in the middle of a frame
    push(2'd2, 8'h77);
    i_req_valid = 4'b0100;
    wait_start("rstmid_start");
    i_req_valid = 4'b0;
    i_tx_busy   = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rstmid_pre_active", o_active, 1);
    i_rstn = 1'b1;
    #1;
    chk("rstmid_ack", o_req_ack, 0);
    chk("rstmid_start", o_tx_start, 0);
    chk("rstmid_data", o_tx_data, 0);
    chk("rstmid_grant_id", o_grant_id, 0);
    chk("rstmid_timeout", o_timeout, 0);
    chk("rstmid_active", o_active, 0);
    @(negedge i_clk);
    i_tx_busy  = 1'b0;
    i_rstn     = 1'b0;
    i_req_data = 32'h9D00_B400;
    push(2'd1, 8'hB4);
    push(2'd3, 8'h9D);
    frames(2, 4'b1010);
    repeat (3) @(negedge i_clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART `sender` between N byte sources (e.g. the receiver echo path plus status/message generators). It accepts one byte at a time from a requester via a valid/ack handshake, issues a one-cycle `start` with stable data to the sender, then tracks the sender's `busy` until the frame completes. A watchdog aborts a grant whose `busy` never rises.

## Interface
- `N`, default 4: number of requesters, minimum 2.
- `IDW`, default 2: grant index width, equal to clog2(N).
- `BUSY_WAIT`, default 16: cycles allowed for `tx_busy` to rise after `tx_start`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-high (1 = reset).
- `req_valid`  in  N  per-requester byte-pending flag; held until acked.
- `req_data`  in  8*N  requester i's byte on bits [8i+7:8i].
- `req_ack`  out  N  one-hot, one-cycle pulse: requester's byte was taken.
- `tx_start`  out  1  one-cycle start pulse to the sender.
- `tx_data`  out  8  byte to the sender; stable from the start pulse until return to IDLE.
- `tx_busy`  in  1  sender busy.
- `grant_id`  out  IDW  index of the last granted requester.
- `active`  out  1  high whenever state ≠ IDLE.
- `timeout`  out  1  one-cycle pulse when the busy watchdog expires.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE. `active` = (state ≠ IDLE).
- **IDLE:**
  - If any `req_valid` bit is set and `tx_busy` = 0, select the winner w as the first set bit searching upward from pointer `ptr`, wrapping modulo N.
  - Registered on that edge: `tx_start`←1, `tx_data`←req_data[w], `req_ack`←onehot(w), `grant_id`←w, `ptr`←(w+1) mod N, wdog←0, state←WAIT_BUSY.
  - If `tx_busy` = 1 in IDLE (sender occupied externally), do not grant.
- **WAIT_BUSY:** wdog increments each cycle.
  - If `tx_busy` = 1, go to WAIT_DONE.
  - Otherwise, if wdog = BUSY_WAIT−1, pulse `timeout` and go to IDLE.
  - If `tx_busy` = 1 and wdog expiry occur in the same cycle, `tx_busy` wins: go to WAIT_DONE with no timeout.
- **WAIT_DONE:** when `tx_busy` = 0, go to IDLE. There is no upper bound on dwell time.
- `tx_start` and `req_ack` are cleared on the cycle after they assert. At most one `req_ack` bit is ever high.
- `req_valid` is sampled only in IDLE. A requester that keeps `valid` high after its ack is treated as offering its next byte, and competes on the next IDLE cycle under round-robin.
- `ptr` advances only on grant; it does not advance on timeout and is not rewound after one.
- Pointer and index arithmetic is modulo N. For non-power-of-2 N, indices ≥ N never win.
- Reset (asynchronous, any state):
  - state←IDLE, `ptr`←0, wdog←0.
  - `req_ack`, `tx_start`, `tx_data`, `grant_id`, `timeout` all ←0; `active`←0.
  - A byte in flight is abandoned; the sender is reset separately.

## Timing
- Grant latency: `req_valid` seen in IDLE at edge k produces `tx_start`/`req_ack` high during cycle k+1.
- Minimum frame spacing: one IDLE cycle after `tx_busy` falls.
  - `busy` falls at edge m, state reaches IDLE at m+1, next `tx_start` at m+2.
- Timeout: with `busy` stuck low, `timeout` pulses BUSY_WAIT cycles after `tx_start`. The next grant is possible one cycle later.
- `tx_data` changes only on a grant edge or on reset.

## Test plan
- **Single request:** after reset, req_valid=4'b0100 with req_data byte2=8'hA5. Required: one cycle later `req_ack`=4'b0100, `tx_start`=1, `tx_data`=8'hA5, `grant_id`=2. Drive `busy` high for 10 cycles; `active` falls 1 cycle after `busy` falls.
- **Round-robin fairness:** hold req_valid=4'b1111 continuously with a behavioral sender (busy 5 cycles). Required: grant order 0,1,2,3,0,1…; each `req_ack` is exactly one cycle wide.
- **Wrap and skip:** ptr=3 (after granting 2), req_valid=4'b0011. Required: grant 0, then 1, then 0 (requester 3 skipped, pointer wraps).
- **Watchdog:** grant with `tx_busy` held 0. Required: `timeout` pulses exactly 16 cycles after `tx_start`, then state IDLE. Repeat with `busy` rising on wdog=15: no timeout, state WAIT_DONE.
- **Sender busy in IDLE:** `tx_busy`=1 externally while req_valid=4'b0001. Required: no ack or start until `busy`=0; grant follows one cycle after.
- **Reset mid-frame:** assert `rstn`=1 during WAIT_DONE. Required: all outputs 0 immediately (asynchronous), `ptr`=0; after release with req_valid=4'b1010, requester 1 is granted first.
